// File: rtl/pixel_frame_controller_if.sv
// Signal bundle around the frame controller: pixel stream framing in, buffer write
// port out, and the start/done handshake with the inference engine.
interface pixel_frame_controller_if #(
    parameter int data_width = 16,
    parameter int addr_width = 9
);
    logic                  pause_r;
    logic                  freeze_r;
    logic                  done_in;
    logic [data_width-1:0] pix_in;
    logic                  wr_en;
    logic [addr_width-1:0] wr_addr;
    logic [data_width-1:0] wr_data;
    logic                  nn_start;
    logic                  nn_done;
    logic                  frame_ready;

    modport master (
        input  pause_r, freeze_r, done_in, pix_in, nn_done,
        output wr_en, wr_addr, wr_data, nn_start, frame_ready
    );

    modport slave (
        output pause_r, freeze_r, done_in, pix_in, nn_done,
        input  wr_en, wr_addr, wr_data, nn_start, frame_ready
    );
endinterface

// File: rtl/pixel_frame_controller.sv
// Frame capture sequencer: converts pause/freeze/done framing into linear buffer
// writes, checks frame geometry and hands good frames to the inference engine.
module pixel_frame_controller #(
    parameter int image_width  = 18,
    parameter int image_height = 18,
    parameter int data_width   = 16,
    parameter int addr_width   = $clog2(image_width * image_height)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    pixel_frame_controller_if.master bus,
    output logic                     frame_err,
    output logic [7:0]               dropped_cnt,
    output logic [2:0]               state_o
);
    localparam int total = image_width * image_height;
    localparam int col_w = (image_width > 1) ? $clog2(image_width) : 1;
    localparam int row_w = $clog2(image_height + 1);
    localparam int cnt_w = $clog2(total + 1);
    localparam logic [col_w-1:0] col_last = col_w'(image_width - 1);
    localparam logic [row_w-1:0] row_end  = row_w'(image_height);
    localparam logic [cnt_w-1:0] cnt_full = cnt_w'(total);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        CAPTURE  = 3'd2,
        LAUNCH   = 3'd3,
        WAIT_NN  = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [col_w-1:0]      col_reg, col_next;
    logic [row_w-1:0]      row_reg, row_next;
    logic [cnt_w-1:0]      cnt_reg, cnt_next;
    logic                  err_reg, err_next;
    logic                  freeze_q_reg, pause_q_reg, done_q_reg;
    logic                  wr_en_reg, wr_en_next;
    logic [addr_width-1:0] wr_addr_reg, wr_addr_next;
    logic [data_width-1:0] wr_data_reg, wr_data_next;
    logic                  nn_start_reg, nn_start_next;
    logic                  frame_ready_reg, frame_ready_next;
    logic                  frame_err_reg, frame_err_next;
    logic [7:0]            dropped_reg, dropped_next;

    logic                  pv, sof, line_end, eof;
    logic                  take;
    logic [col_w-1:0]      base_col;
    logic [row_w-1:0]      base_row;
    logic [cnt_w-1:0]      base_cnt;

    assign pv       = ~bus.pause_r & ~bus.freeze_r;
    assign sof      = freeze_q_reg & ~bus.freeze_r;
    assign line_end = ~pause_q_reg & bus.pause_r & ~bus.freeze_r;
    assign eof      = ~done_q_reg & bus.done_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            col_reg         <= '0;
            row_reg         <= '0;
            cnt_reg         <= '0;
            err_reg         <= 1'b0;
            freeze_q_reg    <= 1'b1;
            pause_q_reg     <= 1'b1;
            done_q_reg      <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            nn_start_reg    <= 1'b0;
            frame_ready_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            dropped_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            row_reg         <= row_next;
            cnt_reg         <= cnt_next;
            err_reg         <= err_next;
            freeze_q_reg    <= bus.freeze_r;
            pause_q_reg     <= bus.pause_r;
            done_q_reg      <= bus.done_in;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
            nn_start_reg    <= nn_start_next;
            frame_ready_reg <= frame_ready_next;
            frame_err_reg   <= frame_err_next;
            dropped_reg     <= dropped_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        cnt_next       = cnt_reg;
        err_next       = err_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        frame_err_next = 1'b0;
        dropped_next   = dropped_reg;
        take           = 1'b0;
        base_col       = col_reg;
        base_row       = row_reg;
        base_cnt       = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (arm) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!arm) begin
                    state_next = IDLE;
                end else if (sof) begin
                    // A pixel valid in the SOF cycle itself becomes pixel 0.
                    state_next = CAPTURE;
                    base_col   = '0;
                    base_row   = '0;
                    base_cnt   = '0;
                    col_next   = '0;
                    row_next   = '0;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    take       = pv;
                end
            end
            CAPTURE: begin
                if (!arm) begin
                    state_next = IDLE;
                end else if (eof) begin
                    if (!err_reg && cnt_reg == cnt_full) begin
                        state_next = LAUNCH;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_SOF;
                    end
                end else if (pv) begin
                    take = 1'b1;
                end else if (line_end && col_reg != '0) begin
                    err_next = 1'b1;
                    col_next = '0;
                    if (row_reg < row_end) row_next = row_reg + 1'b1;
                end
            end
            LAUNCH: begin
                state_next = WAIT_NN;
            end
            WAIT_NN: begin
                if (sof && dropped_reg != 8'hFF) dropped_next = dropped_reg + 8'd1;
                if (bus.nn_done) state_next = arm ? WAIT_SOF : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The row bound keeps writes inside the buffer once short lines have
        // pushed the row past the last line; such a frame is already in error.
        if (take) begin
            if (base_cnt < cnt_full && base_row < row_end) begin
                wr_en_next   = 1'b1;
                wr_addr_next = addr_width'(int'(base_row) * image_width + int'(base_col));
                wr_data_next = bus.pix_in;
                cnt_next     = base_cnt + 1'b1;
                if (base_col == col_last) begin
                    col_next = '0;
                    row_next = base_row + 1'b1;
                end else begin
                    col_next = base_col + 1'b1;
                end
            end else begin
                err_next = 1'b1;
            end
        end

        nn_start_next    = (state_next == LAUNCH);
        frame_ready_next = (state_next == WAIT_NN);
    end

    assign bus.wr_en       = wr_en_reg;
    assign bus.wr_addr     = wr_addr_reg;
    assign bus.wr_data     = wr_data_reg;
    assign bus.nn_start    = nn_start_reg;
    assign bus.frame_ready = frame_ready_reg;
    assign frame_err       = frame_err_reg;
    assign dropped_cnt     = dropped_reg;
    assign state_o         = state_reg;
endmodule

// File: tb/tb_pixel_frame_controller.sv
// Bench for pixel_frame_controller: frame-level table vectors, hand-written corner
// sequences and randomized frames checked against a per-frame expectation model.
module tb_pixel_frame_controller;
    localparam int W     = 18;
    localparam int H     = 18;
    localparam int DW    = 16;
    localparam int AW    = $clog2(W * H);
    localparam int TOTAL = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       frame_err;
    logic [7:0] dropped_cnt;
    logic [2:0] state_o;

    pixel_frame_controller_if #(.data_width(DW), .addr_width(AW)) bus ();

    pixel_frame_controller #(
        .image_width(W), .image_height(H), .data_width(DW), .addr_width(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .arm(arm),
        .bus(bus),
        .frame_err(frame_err),
        .dropped_cnt(dropped_cnt),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        string name;
        int    nlines;
        int    short_line;
        int    short_len;
        int    extra_px;
        bit    exp_launch;
    } vec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    wr_t  wr_q[$];
    wr_t  exp_q[$];
    int   line_len[32];
    int   start_cnt = 0;
    int   ferr_cnt = 0;
    time  start_t, ferr_t, eof_t;
    logic fr_at_start;
    vec_t vecs[5];

    // Observed side: every write and pulse seen on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
        if (bus.nn_start) begin
            start_cnt++;
            start_t = $time;
            fr_at_start = bus.frame_ready;
        end
        if (frame_err) begin
            ferr_cnt++;
            ferr_t = $time;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic f, input logic d,
                         input logic [DW-1:0] px, input logic nd);
        @(negedge clk);
        bus.pause_r  = p;
        bus.freeze_r = f;
        bus.done_in  = d;
        bus.pix_in   = px;
        bus.nn_done  = nd;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic gap();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic pixel(input logic [DW-1:0] px);
        drive(1'b0, 1'b0, 1'b0, px, 1'b0);
    endtask

    task automatic build_lines(input int n, input int short_line, input int short_len, input int extra);
        for (int l = 0; l < 32; l++) line_len[l] = W;
        if (short_line >= 0) line_len[short_line] = short_len;
        if (extra > 0) line_len[n] = extra;
    endtask

    // A frame is launched only with exactly H lines of exactly W pixels.
    function automatic bit model_launch(input int n);
        if (n != H) return 1'b0;
        for (int l = 0; l < n; l++) if (line_len[l] != W) return 1'b0;
        return 1'b1;
    endfunction

    // Pixel i of line l lands at l*W+i while the buffer still has room.
    task automatic send_frame(input int n, input int arm_on, input int arm_off);
        logic [DW-1:0] px;
        int            k;
        bit            capturing;
        k = 0;
        capturing = (arm_on < 0);
        repeat (3) idle();
        for (int l = 0; l < n; l++) begin
            if (l == arm_on) arm = 1'b1;
            if (l == arm_off) begin
                arm = 1'b0;
                capturing = 1'b0;
            end
            for (int i = 0; i < line_len[l]; i++) begin
                px = DW'($urandom);
                if (capturing && i < W && l < H && k < TOTAL) exp_q.push_back({AW'(l * W + i), px});
                k++;
                pixel(px);
            end
            repeat (4) gap();
        end
        repeat (2) idle();
        drive(1'b1, 1'b1, 1'b1, '0, 1'b0);
        eof_t = $time;
        drive(1'b1, 1'b1, 1'b1, '0, 1'b0);
        idle();
    endtask

    task automatic run_frame(input string name, input int n, input bit exp_launch,
                             input int arm_on, input int arm_off);
        int bad;
        bit exp_ferr;
        exp_ferr = !exp_launch && arm_on < 0 && arm_off < 0;
        wr_q.delete();
        exp_q.delete();
        start_cnt = 0;
        ferr_cnt = 0;
        send_frame(n, arm_on, arm_off);
        repeat (3) idle();
        check({name, " writes"}, wr_q.size(), exp_q.size());
        bad = 0;
        foreach (exp_q[i]) if (i < wr_q.size() && wr_q[i] !== exp_q[i]) bad++;
        check({name, " write content"}, bad, 0);
        check({name, " nn_start pulses"}, start_cnt, exp_launch ? 1 : 0);
        check({name, " frame_err pulses"}, ferr_cnt, exp_ferr ? 1 : 0);
        if (exp_launch) begin
            check({name, " nn_start latency"}, 32'(start_t - eof_t), 10);
            check({name, " frame_ready at launch"}, 32'(fr_at_start), 0);
            check({name, " frame_ready"}, 32'(bus.frame_ready), 1);
            check({name, " state WAIT_NN"}, 32'(state_o), 4);
        end
        if (exp_ferr) check({name, " frame_err latency"}, 32'(ferr_t - eof_t), 10);
        $display("frame %s: lines=%0d writes=%0d nn_start=%0d frame_err=%0d",
                 name, n, wr_q.size(), start_cnt, ferr_cnt);
    endtask

    task automatic finish_nn(input string name);
        check({name, " frame_ready held"}, 32'(bus.frame_ready), 1);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        idle();
        check({name, " frame_ready after nn_done"}, 32'(bus.frame_ready), 0);
        check({name, " state after nn_done"}, 32'(state_o), arm ? 1 : 0);
    endtask

    task automatic sof_burst(input int n);
        for (int s = 0; s < n; s++) begin
            idle();
            pixel(DW'($urandom));
        end
        idle();
    endtask

    initial begin
        vecs[0] = '{"good", 18, -1, 18, 0, 1'b1};
        vecs[1] = '{"short_line5", 18, 5, 17, 0, 1'b0};
        vecs[2] = '{"good_after_err", 18, -1, 18, 0, 1'b1};
        vecs[3] = '{"overrun325", 18, -1, 18, 1, 1'b0};
        vecs[4] = '{"missing_line", 17, -1, 18, 0, 1'b0};

        bus.pause_r  = 1'b1;
        bus.freeze_r = 1'b1;
        bus.done_in  = 1'b0;
        bus.pix_in   = '0;
        bus.nn_done  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset wr_en", 32'(bus.wr_en), 0);
        check("reset wr_addr", 32'(bus.wr_addr), 0);
        check("reset wr_data", 32'(bus.wr_data), 0);
        check("reset nn_start", 32'(bus.nn_start), 0);
        check("reset frame_ready", 32'(bus.frame_ready), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset dropped_cnt", 32'(dropped_cnt), 0);
        check("reset state", 32'(state_o), 0);
        rst_n = 1'b1;
        repeat (2) idle();
        check("idle without arm", 32'(state_o), 0);
        arm = 1'b1;
        repeat (2) idle();
        check("armed state", 32'(state_o), 1);

        // Table of whole-frame vectors.
        for (int v = 0; v < 5; v++) begin
            build_lines(vecs[v].nlines, vecs[v].short_line, vecs[v].short_len, vecs[v].extra_px);
            run_frame(vecs[v].name, vecs[v].nlines + (vecs[v].extra_px > 0 ? 1 : 0),
                      vecs[v].exp_launch, -1, -1);
            if (vecs[v].exp_launch) finish_nn(vecs[v].name);
        end

        // Drops while busy, then nn_done coinciding with SOF.
        build_lines(H, -1, W, 0);
        run_frame("drop_base", H, 1'b1, -1, -1);
        wr_q.delete();
        sof_burst(3);
        check("dropped after 3 SOF", 32'(dropped_cnt), 3);
        idle();
        drive(1'b0, 1'b0, 1'b0, DW'($urandom), 1'b1);
        repeat (5) pixel(DW'($urandom));
        repeat (2) idle();
        check("dropped with nn_done+SOF", 32'(dropped_cnt), 4);
        check("no writes while busy", wr_q.size(), 0);
        check("state after nn_done+SOF", 32'(state_o), 1);
        $display("sequence drop: dropped_cnt=%0d", dropped_cnt);

        // Saturation of the drop counter.
        build_lines(H, -1, W, 0);
        run_frame("sat_base", H, 1'b1, -1, -1);
        sof_burst(300);
        check("dropped saturates", 32'(dropped_cnt), 255);
        finish_nn("sat_base");
        $display("sequence saturate: dropped_cnt=%0d", dropped_cnt);

        // Arm raised mid-frame: nothing is captured until the next SOF.
        arm = 1'b0;
        repeat (2) idle();
        check("disarm to IDLE", 32'(state_o), 0);
        build_lines(H, -1, W, 0);
        run_frame("arm_mid_frame", H, 1'b0, 3, -1);
        check("arm_mid_frame state", 32'(state_o), 1);
        run_frame("after_arm_mid", H, 1'b1, -1, -1);
        finish_nn("after_arm_mid");

        // Arm dropped during capture: abort, writes stop after line 3.
        run_frame("arm_off", H, 1'b0, -1, 4);
        check("arm_off state", 32'(state_o), 0);
        arm = 1'b1;
        repeat (2) idle();

        // Randomized frames against the frame-level model.
        for (int r = 0; r < 6; r++) begin
            int  n;
            int  mut;
            bit  exp;
            mut = int'($urandom_range(0, 3));
            n = H;
            build_lines(H, -1, W, 0);
            case (mut)
                1: line_len[$urandom_range(0, H - 1)] = int'($urandom_range(10, W - 1));
                2: n = H - 1;
                3: begin
                    line_len[H] = int'($urandom_range(1, 3));
                    n = H + 1;
                end
                default: n = H;
            endcase
            exp = model_launch(n);
            run_frame($sformatf("random%0d_m%0d", r, mut), n, exp, -1, -1);
            if (exp) finish_nn($sformatf("random%0d", r));
        end

        // Asynchronous reset in the middle of a capture.
        wr_q.delete();
        repeat (2) idle();
        for (int i = 0; i < 10; i++) pixel(DW'($urandom));
        check("pre-reset wr_en", 32'(bus.wr_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset wr_en", 32'(bus.wr_en), 0);
        check("async reset wr_addr", 32'(bus.wr_addr), 0);
        check("async reset wr_data", 32'(bus.wr_data), 0);
        check("async reset frame_ready", 32'(bus.frame_ready), 0);
        check("async reset dropped_cnt", 32'(dropped_cnt), 0);
        check("async reset state", 32'(state_o), 0);
        repeat (2) idle();
        rst_n = 1'b1;
        $display("sequence reset: state=%0d dropped_cnt=%0d", state_o, dropped_cnt);
        build_lines(H, -1, W, 0);
        run_frame("after_reset", H, 1'b1, -1, -1);
        finish_nn("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_frame_controller.md
# pixel_frame_controller

Sequences frame capture from `pixel_stream_block` into the image buffer and hands completed frames to the inference engine. It consumes the registered pause/freeze/done/data outputs of the stream block, generates linear buffer write addresses, and validates frame geometry. It issues a one-cycle start to the network and blocks further capture until the network reports done. Frames that arrive while the network is busy are counted and dropped.

## Interface
- `image_width`, 18: valid pixels per line
- `image_height`, 18: valid lines per frame
- `data_width`, 16: pixel width
- `addr_width`, `$clog2(image_width*image_height)`: buffer address width (derived)

- `clk` in 1: single clock for all logic
- `rst_n` in 1: asynchronous, active-low reset
- `arm` in 1: capture enable; level
- `pause_r` in 1: high = outside active line (from stream block)
- `freeze_r` in 1: high = outside active frame (from stream block)
- `done_in` in 1: frame-end level from stream block; rising edge marks end of frame
- `pix_in` in `data_width`: pixel data, aligned with `pause_r`/`freeze_r`
- `nn_done` in 1: one-cycle pulse, inference finished
- `wr_en` out 1: buffer write strobe
- `wr_addr` out `addr_width`: linear address, row*image_width+col
- `wr_data` out `data_width`: pixel to write
- `nn_start` out 1: one-cycle inference start pulse
- `frame_ready` out 1: buffer holds a valid frame owned by the network
- `frame_err` out 1: one-cycle pulse, captured frame rejected
- `dropped_cnt` out 8: frames skipped while busy, saturating
- `state_o` out 3: current state encoding, for debug

## Operation
- Pixel valid `pv = ~pause_r & ~freeze_r`. Start-of-frame (SOF) = `freeze_r` 1→0 edge. Line end = `pause_r` 0→1 edge while `freeze_r`=0. End-of-frame (EOF) = `done_in` 0→1 edge. Edge detection uses registered previous values, which reset to 1 for `freeze_r`/`pause_r` and to 0 for `done_in`.
- States: IDLE=0, WAIT_SOF=1, CAPTURE=2, LAUNCH=3, WAIT_NN=4.
- IDLE: if `arm`=1, go to WAIT_SOF. A frame already in progress is never joined mid-way; only SOF starts capture.
- WAIT_SOF:
  - `arm`=0 → IDLE.
  - SOF → CAPTURE. Clear col, row, and the err flag.
  - If `pv` is asserted in the SOF cycle, that pixel is captured as pixel 0.
- CAPTURE, on each `pv` cycle:
  - If count < image_width*image_height: write `pix_in` at row*image_width+col. col increments and wraps at image_width-1, with row incrementing on the wrap.
  - Otherwise: no write; set err (overrun).
- CAPTURE, at line end: if col≠0, set err (short or long line). col then realigns to 0 and row increments.
- CAPTURE, at EOF:
  - If err=0 and count = image_width*image_height → LAUNCH.
  - Otherwise → pulse `frame_err` and go to WAIT_SOF, or to IDLE if `arm`=0.
- CAPTURE with `arm` 1→0: abort immediately to IDLE. No `nn_start`, no `frame_err`.
- LAUNCH: `nn_start`=1 for exactly this cycle, then WAIT_NN.
- WAIT_NN: `frame_ready`=1. Each SOF increments `dropped_cnt`, saturating at 255. On `nn_done` → WAIT_SOF if `arm`=1, else IDLE. `arm` is ignored until `nn_done` arrives.
- `nn_done` outside WAIT_NN is ignored.
- Simultaneous events:
  - `nn_done` and SOF in the same cycle: the frame counts as dropped.
  - EOF and SOF in the same cycle in CAPTURE: EOF is processed; the SOF is missed.
- `dropped_cnt` clears only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, col/row/err 0, `dropped_cnt`=0.
- `wr_en`/`wr_addr`/`wr_data` are registered and assert in the cycle after the sampled `pv`. Throughput is 1 pixel per clock.
- EOF edge sampled in cycle N → `nn_start`=1 in cycle N+1 (LAUNCH). `frame_ready` rises at N+2 and falls in the cycle after `nn_done` is sampled.
- The `frame_err` pulse occurs in cycle N+1 for EOF sampled at N.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- 18×18 frame, 18 pv cycles per line with 4-cycle gaps, then EOF → 324 writes at addresses 0..323, with `wr_data` equal to the sent pixel. `nn_start` pulses once, 1 cycle after EOF; `frame_ready`=1 until `nn_done`.
- Line 5 carries 17 pixels → `frame_err` pulses once after EOF; no `nn_start`; the next good frame launches normally.
- 325 pixels in a frame → the 325th pixel is not written; `frame_err` pulses; `nn_start` stays 0.
- Three SOFs during WAIT_NN → `dropped_cnt`=3; with 300 SOFs it saturates at 255.
- `arm` asserted mid-frame → no writes until the next SOF; `arm` deasserted in CAPTURE → IDLE next cycle, writes stop.
- `rst_n` low mid-CAPTURE → all outputs 0 immediately, state_o=0; after release with `arm`=1, the next full frame captures from address 0.
